// File: rtl/regwr_port_arbiter.sv
// regwr_port_arbiter
//   Shares the single register-file write port between the ALU writeback
//   path (req0, rd destination) and the load writeback path (req1, rt
//   destination). At most one requester is granted per cycle. Ties are
//   broken round-robin. The granted write is presented one cycle later as a
//   registered command. Writes to register 0 are accepted but not enabled.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   stall             pipeline stall, blocks all grants in the same cycle
//   reqN_valid/addr/data  write request from requester N
//   reqN_ready        combinational grant to requester N
//   mux_sel           registered destination-mux select (0 = req0, 1 = req1)
//   wr_en/addr/data   registered register-file write command
//   contention_cnt    saturating count of unstalled cycles with both valid
module regwr_port_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          mux_sel,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [CW-1:0] contention_cnt
);

  typedef enum logic {FAV0 = 1'b0, FAV1 = 1'b1} prio_t;

  prio_t prio, prio_nxt;

  logic          grant0_p0, grant1_p0, xfer_p0, both_p0;
  logic          sel_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] data_p0;

  logic          mux_sel_p1, wr_en_p1;
  logic [AW-1:0] wr_addr_p1;
  logic [DW-1:0] wr_data_p1;
  logic [CW-1:0] cnt_p1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  // ---- stage p0: combinational grant and pointer next-state ----
  // rst_n gates the grants so that neither ready asserts while in reset.
  always_comb begin
    grant0_p0 = 1'b0;
    grant1_p0 = 1'b0;
    prio_nxt  = prio;
    if (rst_n && !stall) begin
      if (req0_valid && (!req1_valid || prio == FAV0)) grant0_p0 = 1'b1;
      else if (req1_valid)                              grant1_p0 = 1'b1;
    end
    if (grant0_p0)      prio_nxt = FAV1;
    else if (grant1_p0) prio_nxt = FAV0;
  end

  assign req0_ready = grant0_p0;
  assign req1_ready = grant1_p0;
  assign xfer_p0    = grant0_p0 | grant1_p0;
  assign both_p0    = req0_valid & req1_valid & ~stall;
  assign sel_p0     = grant1_p0;
  assign addr_p0    = grant1_p0 ? req1_addr : req0_addr;
  assign data_p0    = grant1_p0 ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio <= FAV0;
    else        prio <= prio_nxt;
  end

  // ---- stage p1: registered write command and contention counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_sel_p1 <= 1'b0;
      wr_en_p1   <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      cnt_p1     <= '0;
    end else begin
      wr_en_p1 <= xfer_p0 & (addr_p0 != '0);
      if (xfer_p0) begin
        mux_sel_p1 <= sel_p0;
        wr_addr_p1 <= addr_p0;
        wr_data_p1 <= data_p0;
      end
      if (both_p0) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign mux_sel        = mux_sel_p1;
  assign wr_en          = wr_en_p1;
  assign wr_addr        = wr_addr_p1;
  assign wr_data        = wr_data_p1;
  assign contention_cnt = cnt_p1;

endmodule
